reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_if.sv | 30 +++
 rtl/reg_file_sb.sv | 111 +++++++++++
 tb/tb_reg_file_sb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-side bundle for the scoreboarded register file.
// master: pipeline side driving addresses and commands; slave: the register file.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) ();
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] reg_write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              mark_busy;
    logic [ADDR_W-1:0] mark_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output rs, rt, rd, reg_write_data, reg_write, mark_busy, mark_addr, clr_req,
        input  read_data_1, read_data_2, rs_busy, rt_busy, clr_busy
    );

    modport slave (
        input  rs, rt, rd, reg_write_data, reg_write, mark_busy, mark_addr, clr_req,
        output read_data_1, read_data_2, rs_busy, rt_busy, clr_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-to-read bypass, optional hardwired zero register,
// per-entry busy scoreboard and a one-entry-per-clock clear sweep.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [DEPTH-1:0]              busy_q, busy_d;

    logic is_idle;
    logic commit;
    logic mark;
    logic fwd_rs;
    logic fwd_rt;

    // Qualified write/mark strobes; commit is gated by reset so outputs stay 0 in reset.
    always_comb begin
        is_idle = (state_q == StIdle);
        commit  = rst_n & bus.reg_write & is_idle & ~(ZERO_REG && (bus.rd == '0));
        mark    = bus.mark_busy & is_idle & ~(ZERO_REG && (bus.mark_addr == '0));
        fwd_rs  = BYPASS && commit && (bus.rd == bus.rs);
        fwd_rt  = BYPASS && commit && (bus.rd == bus.rt);
    end

    // Combinational read ports and busy lookups; forwarding only ever happens in IDLE.
    always_comb begin
        if (ZERO_REG && (bus.rs == '0)) begin
            bus.read_data_1 = '0;
        end else if (fwd_rs) begin
            bus.read_data_1 = bus.reg_write_data;
        end else begin
            bus.read_data_1 = mem_q[bus.rs];
        end

        if (ZERO_REG && (bus.rt == '0)) begin
            bus.read_data_2 = '0;
        end else if (fwd_rt) begin
            bus.read_data_2 = bus.reg_write_data;
        end else begin
            bus.read_data_2 = mem_q[bus.rt];
        end

        bus.rs_busy  = busy_q[bus.rs] & ~fwd_rs;
        bus.rt_busy  = busy_q[bus.rt] & ~fwd_rt;
        bus.clr_busy = (state_q == StSweep);
    end

    // Next-state for array, scoreboard and clear sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (commit) begin
                    mem_d[bus.rd]  = bus.reg_write_data;
                    busy_d[bus.rd] = 1'b0;
                end
                // A new producer supersedes the one retiring this cycle.
                if (mark) begin
                    busy_d[bus.mark_addr] = 1'b1;
                end
                if (bus.clr_req) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                    busy_d  = '0;
                end
            end
            StSweep: begin
                mem_d[cnt_q] = '0;
                busy_d       = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mem_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle number,
// a negedge monitor pops and compares them. Two DUTs share stimulus (BYPASS=1/0).
module tb_reg_file_sb;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic clk;
    logic rst_n;
    int   cycle;
    int   checks;
    int   failures;

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    assign bus_b.rs             = bus_a.rs;
    assign bus_b.rt             = bus_a.rt;
    assign bus_b.rd             = bus_a.rd;
    assign bus_b.reg_write_data = bus_a.reg_write_data;
    assign bus_b.reg_write      = bus_a.reg_write;
    assign bus_b.mark_busy      = bus_a.mark_busy;
    assign bus_b.mark_addr      = bus_a.mark_addr;
    assign bus_b.clr_req        = bus_a.clr_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Signal selector: 0..4 bypass DUT rd1/rd2/rs_busy/rt_busy/clr_busy, 5..8 no-bypass DUT.
    function automatic logic [15:0] actual(input int sig);
        case (sig)
            0:       return bus_a.read_data_1;
            1:       return bus_a.read_data_2;
            2:       return {15'd0, bus_a.rs_busy};
            3:       return {15'd0, bus_a.rt_busy};
            4:       return {15'd0, bus_a.clr_busy};
            5:       return bus_b.read_data_1;
            6:       return bus_b.read_data_2;
            7:       return {15'd0, bus_b.rs_busy};
            default: return {15'd0, bus_b.clr_busy};
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            exp_t e;
            logic [15:0] act;
            e   = exp_q.pop_front();
            act = actual(e.sig);
            checks = checks + 1;
            if (e.cyc != cycle || act !== e.val) begin
                failures = failures + 1;
                $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d, tagged %0d)",
                         e.name, act, e.val, cycle, e.cyc);
            end
        end
    end

    task automatic step(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [15:0] wd, input logic we, input logic mb,
                        input logic [2:0] ma, input logic clr);
        @(posedge clk);
        #1;
        bus_a.rs             = rs;
        bus_a.rt             = rt;
        bus_a.rd             = rd;
        bus_a.reg_write_data = wd;
        bus_a.reg_write      = we;
        bus_a.mark_busy      = mb;
        bus_a.mark_addr      = ma;
        bus_a.clr_req        = clr;
    endtask

    task automatic expect_v(input string name, input int sig, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        e.cyc  = cycle;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] fill;
        cycle    = 0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_a.rs = '0; bus_a.rt = '0; bus_a.rd = '0; bus_a.reg_write_data = '0;
        bus_a.reg_write = 1'b0; bus_a.mark_busy = 1'b0; bus_a.mark_addr = '0;
        bus_a.clr_req = 1'b0;

        // Outputs stay zero in reset even with a write pending.
        step(3, 3, 3, 16'h1234, 1, 1, 3, 0);
        expect_v("rst_rd1", 0, 16'h0000);
        expect_v("rst_rd2", 1, 16'h0000);
        expect_v("rst_rs_busy", 2, 16'h0);
        expect_v("rst_clr_busy", 4, 16'h0);
        expect_v("rst_nb_rd1", 5, 16'h0000);
        step(0, 0, 0, 16'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_v("post_rst_rd1", 0, 16'h0000);

        // Write r3, bypass visible same cycle only on BYPASS=1.
        step(3, 0, 3, 16'h1234, 1, 0, 0, 0);
        expect_v("wr3_bypass", 0, 16'h1234);
        expect_v("wr3_nb_old", 5, 16'h0000);
        step(3, 3, 0, 16'h0, 0, 0, 0, 0);
        expect_v("rd3_p1", 0, 16'h1234);
        expect_v("rd3_p2", 1, 16'h1234);
        expect_v("rd3_nb_p2", 6, 16'h1234);

        step(5, 3, 5, 16'hBEEF, 1, 0, 0, 0);
        expect_v("wr5_bypass", 0, 16'hBEEF);
        expect_v("wr5_nb_old", 5, 16'h0000);
        expect_v("wr5_rd2", 1, 16'h1234);
        step(5, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("rd5_nb", 5, 16'hBEEF);

        // Zero register: writes and marks to r0 are dropped.
        step(0, 0, 0, 16'hFFFF, 1, 0, 0, 0);
        expect_v("r0_wr_bypass", 0, 16'h0000);
        expect_v("r0_wr_nb", 5, 16'h0000);
        step(0, 0, 0, 16'h0, 0, 1, 0, 0);
        expect_v("r0_read", 0, 16'h0000);
        step(0, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("r0_busy", 2, 16'h0);

        // Scoreboard: mark takes effect next cycle, commit clears via bypass.
        step(2, 2, 0, 16'h0, 0, 1, 2, 0);
        expect_v("mark_r2_same_cyc", 2, 16'h0);
        step(2, 2, 0, 16'h0, 0, 0, 0, 0);
        expect_v("r2_rs_busy", 2, 16'h1);
        expect_v("r2_rt_busy", 3, 16'h1);
        expect_v("r2_nb_busy", 7, 16'h1);
        step(2, 0, 2, 16'h2222, 1, 0, 0, 0);
        expect_v("commit_r2_busy", 2, 16'h0);
        expect_v("commit_r2_data", 0, 16'h2222);
        expect_v("commit_r2_nb_busy", 7, 16'h1);
        step(2, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("after_commit_busy", 2, 16'h0);
        expect_v("after_commit_nb_busy", 7, 16'h0);
        step(2, 0, 2, 16'h3333, 1, 1, 2, 0);
        expect_v("set_clr_same_data", 0, 16'h3333);
        step(2, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("set_wins_busy", 2, 16'h1);
        expect_v("set_wins_nb_busy", 7, 16'h1);

        // Fill all registers, then mark r6 and start a sweep.
        for (int i = 0; i < 8; i++) begin
            fill = 16'h00A0 + 16'(i);
            step(3'(i), 0, 3'(i), fill, 1, 0, 0, 0);
            expect_v("fill_bypass", 0, (i == 0) ? 16'h0000 : fill);
        end
        step(7, 1, 0, 16'h0, 0, 1, 6, 0);
        expect_v("fill_r7", 0, 16'h00A7);
        expect_v("fill_r1", 1, 16'h00A1);
        step(6, 6, 0, 16'h0, 0, 0, 0, 1);
        expect_v("pre_sweep_busy", 2, 16'h1);
        expect_v("pre_sweep_clr_busy", 4, 16'h0);
        for (int s = 0; s < 8; s++) begin
            case (s)
                0: begin
                    step(6, 6, 0, 16'h0, 0, 0, 0, 0);
                    expect_v("sweep_busy_cleared", 2, 16'h0);
                end
                2: begin
                    step(4, 0, 4, 16'h5555, 1, 1, 4, 0);
                    expect_v("sweep_no_bypass", 0, 16'h00A4);
                end
                3: begin
                    step(4, 4, 0, 16'h0, 0, 0, 0, 0);
                    expect_v("sweep_wr_ignored", 0, 16'h00A4);
                    expect_v("sweep_mark_ignored", 3, 16'h0);
                end
                4: step(4, 0, 0, 16'h0, 0, 0, 0, 1);
                5: begin
                    step(4, 0, 0, 16'h0, 0, 0, 0, 0);
                    expect_v("sweep_r4_zeroed", 0, 16'h0000);
                end
                7: begin
                    step(7, 0, 0, 16'h0, 0, 0, 0, 0);
                    expect_v("sweep_last_raw", 0, 16'h00A7);
                end
                default: step(0, 0, 0, 16'h0, 0, 0, 0, 0);
            endcase
            expect_v("sweep_clr_busy", 4, 16'h1);
            expect_v("sweep_nb_clr_busy", 8, 16'h1);
        end
        step(0, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("sweep_done", 4, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step(3'(i), 3'(7 - i), 0, 16'h0, 0, 0, 0, 0);
            expect_v("swept_p1", 0, 16'h0000);
            expect_v("swept_p2", 1, 16'h0000);
            expect_v("swept_busy", 2, 16'h0);
        end
        step(1, 0, 1, 16'h0101, 1, 0, 0, 0);
        expect_v("first_commit_bypass", 0, 16'h0101);
        step(7, 1, 7, 16'h7777, 1, 0, 0, 0);
        expect_v("r1_after_sweep", 1, 16'h0101);

        // Reset in the middle of a sweep.
        step(7, 1, 0, 16'h0, 0, 0, 0, 1);
        expect_v("pre_sweep2_r7", 0, 16'h7777);
        for (int s = 0; s < 3; s++) begin
            step(7, 1, 0, 16'h0, 0, 0, 0, 0);
            expect_v("sweep2_clr_busy", 4, 16'h1);
        end
        step(7, 1, 0, 16'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        expect_v("midsweep_rst_clr_busy", 4, 16'h0);
        expect_v("midsweep_rst_r7", 0, 16'h0000);
        expect_v("midsweep_rst_r1", 1, 16'h0000);
        step(7, 1, 0, 16'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_v("post_rst2_clr_busy", 4, 16'h0);
        step(7, 1, 6, 16'h6666, 1, 0, 0, 0);
        expect_v("post_rst2_r7", 0, 16'h0000);
        expect_v("post_rst2_r1", 1, 16'h0000);
        expect_v("post_rst2_clr_busy_b", 8, 16'h0);
        step(6, 0, 0, 16'h0, 0, 0, 0, 0);
        expect_v("post_rst2_wr_r6", 0, 16'h6666);
        expect_v("post_rst2_wr_r6_nb", 5, 16'h6666);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
